// File: rtl/miner_job_scheduler_if.sv
// miner_job_scheduler_if
// Groups every non-clock/reset signal of the job scheduler:
//   host job side    : job_valid/job_ready, job_midstate, job_data2, job_id, flush
//   mining core side : midstate, data2, start_mining, miner_busy, got_ticket, golden_nonce
//   host result side : res_valid/res_ready, res_found, res_nonce, res_id, res_timeout
//   status           : sched_busy
// slave  = the scheduler itself
// master = whatever surrounds it (host plus core)
interface miner_job_scheduler_if;
   logic         job_valid;
   logic         job_ready;
   logic [255:0] job_midstate;
   logic [95:0]  job_data2;
   logic [3:0]   job_id;
   logic         flush;

   logic [255:0] midstate;
   logic [95:0]  data2;
   logic         start_mining;
   logic         miner_busy;
   logic         got_ticket;
   logic [31:0]  golden_nonce;

   logic         res_valid;
   logic         res_ready;
   logic         res_found;
   logic [31:0]  res_nonce;
   logic [3:0]   res_id;
   logic         res_timeout;

   logic         sched_busy;

   modport slave (
      input  job_valid, job_midstate, job_data2, job_id, flush,
      input  miner_busy, got_ticket, golden_nonce,
      input  res_ready,
      output job_ready, midstate, data2, start_mining,
      output res_valid, res_found, res_nonce, res_id, res_timeout,
      output sched_busy
   );

   modport master (
      output job_valid, job_midstate, job_data2, job_id, flush,
      output miner_busy, got_ticket, golden_nonce,
      output res_ready,
      input  job_ready, midstate, data2, start_mining,
      input  res_valid, res_found, res_nonce, res_id, res_timeout,
      input  sched_busy
   );
endinterface

// File: rtl/miner_job_scheduler.sv
// miner_job_scheduler
// Queues up to two mining jobs from the host, launches them one at a time on
// the hashing core, waits for the core to finish (or never start), and hands
// the result back to the host with a valid/ready handshake.
// Ports:
//   clk  - sole clock
//   rst  - synchronous, active-high reset
//   bus  - miner_job_scheduler_if.slave (host job/result and core signals)
//
// state       | meaning
// ------------+---------------------------------------------------------------
// S_IDLE      | nothing running; pops the FIFO head when one is queued
// S_LAUNCH    | one setup cycle, then start_mining high for START_HOLD cycles
// S_WAIT_BUSY | waiting for the core to raise miner_busy (bounded)
// S_RUN       | core busy; no timeout
// S_SETTLE    | core done; let got_ticket/golden_nonce settle SETTLE cycles
// S_REPORT    | result presented until the host takes it
module miner_job_scheduler #(
   parameter int START_HOLD   = 4,
   parameter int SETTLE       = 4,
   parameter int BUSY_TIMEOUT = 16
) (
   input logic                  clk,
   input logic                  rst,
   miner_job_scheduler_if.slave bus
);

   localparam int MAX_AB = (START_HOLD > SETTLE) ? START_HOLD : SETTLE;
   localparam int MAX_P  = (MAX_AB > BUSY_TIMEOUT) ? MAX_AB : BUSY_TIMEOUT;
   localparam int CW     = $clog2(MAX_P + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_BUSY,
      S_RUN,
      S_SETTLE,
      S_REPORT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [255:0]  fifo_ms_q [2];
   logic [95:0]   fifo_d2_q [2];
   logic [3:0]    fifo_id_q [2];
   logic          wr_ptr_q, rd_ptr_q;
   logic [1:0]    fifo_cnt_q;
   logic          fifo_full;
   logic          push, pop;

   logic [255:0]  act_ms_q;
   logic [95:0]   act_d2_q;
   logic [3:0]    act_id_q;

   logic          res_found_q, res_found_d;
   logic [31:0]   res_nonce_q, res_nonce_d;
   logic [3:0]    res_id_q, res_id_d;
   logic          res_timeout_q, res_timeout_d;

   assign fifo_full = (fifo_cnt_q == 2'd2);
   // Any job offered alongside flush is dropped; flush also blocks the pop.
   assign push = bus.job_valid && !fifo_full && !bus.flush;
   assign pop  = (state_q == S_IDLE) && (fifo_cnt_q != 2'd0) && !bus.flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         fifo_cnt_q <= 2'd0;
      end else if (bus.flush) begin
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         fifo_cnt_q <= 2'd0;
      end else begin
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 2'd1;
         else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - 2'd1;
      end
   end

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_ms_q[wr_ptr_q] <= bus.job_midstate;
         fifo_d2_q[wr_ptr_q] <= bus.job_data2;
         fifo_id_q[wr_ptr_q] <= bus.job_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         act_ms_q <= '0;
         act_d2_q <= '0;
         act_id_q <= '0;
      end else if (pop) begin
         act_ms_q <= fifo_ms_q[rd_ptr_q];
         act_d2_q <= fifo_d2_q[rd_ptr_q];
         act_id_q <= fifo_id_q[rd_ptr_q];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         res_found_q   <= 1'b0;
         res_nonce_q   <= '0;
         res_id_q      <= '0;
         res_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         res_found_q   <= res_found_d;
         res_nonce_q   <= res_nonce_d;
         res_id_q      <= res_id_d;
         res_timeout_q <= res_timeout_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      res_found_d   = res_found_q;
      res_nonce_d   = res_nonce_q;
      res_id_d      = res_id_q;
      res_timeout_d = res_timeout_q;

      case (state_q)
         S_IDLE: begin
            if (pop) state_d = S_LAUNCH;
         end
         S_LAUNCH: begin
            if (bus.flush)                       state_d = S_IDLE;
            else if (cnt_q == CW'(START_HOLD))   state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else if (bus.miner_busy) begin
               state_d = S_RUN;
            end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
               state_d       = S_REPORT;
               res_found_d   = 1'b0;
               res_nonce_d   = '0;
               res_id_d      = act_id_q;
               res_timeout_d = 1'b1;
            end
         end
         S_RUN: begin
            if (bus.flush)            state_d = S_IDLE;
            else if (!bus.miner_busy) state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else if (cnt_q == CW'(SETTLE - 1)) begin
               state_d       = S_REPORT;
               res_found_d   = bus.got_ticket;
               res_nonce_d   = bus.got_ticket ? bus.golden_nonce : 32'd0;
               res_id_d      = act_id_q;
               res_timeout_d = 1'b0;
            end
         end
         S_REPORT: begin
            // flush here only empties the FIFO; the result stays pending
            if (bus.res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Only the timed states count; every state entry restarts from zero.
      if (state_d != state_q)
         cnt_d = '0;
      else if (state_q == S_LAUNCH || state_q == S_WAIT_BUSY || state_q == S_SETTLE)
         cnt_d = cnt_q + 1'b1;
      else
         cnt_d = '0;
   end

   // Count 0 of LAUNCH is the setup cycle where midstate/data2 are already
   // driven but start_mining is still low.
   assign bus.start_mining = (state_q == S_LAUNCH) && (cnt_q != '0);
   assign bus.job_ready    = !fifo_full;
   assign bus.midstate     = act_ms_q;
   assign bus.data2        = act_d2_q;
   assign bus.res_valid    = (state_q == S_REPORT);
   assign bus.res_found    = res_found_q;
   assign bus.res_nonce    = res_nonce_q;
   assign bus.res_id       = res_id_q;
   assign bus.res_timeout  = res_timeout_q;
   assign bus.sched_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_miner_job_scheduler.sv
// tb_miner_job_scheduler
// Directed bench for miner_job_scheduler. Stimulus pushes expected launches
// and results into queues; a monitor pops and compares whenever the DUT
// launches a job or hands over a result. A small core model answers
// start_mining with miner_busy.
module tb_miner_job_scheduler;
   localparam int START_HOLD   = 4;
   localparam int SETTLE       = 4;
   localparam int BUSY_TIMEOUT = 16;

   typedef struct packed {
      logic        found;
      logic [31:0] nonce;
      logic [3:0]  id;
      logic        timeout;
   } res_t;

   typedef struct packed {
      logic [255:0] ms;
      logic [95:0]  d2;
   } job_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   res_t exp_res[$];
   job_t exp_job[$];
   int   n_results = 0;
   int   res_first_cyc = 0;
   int   start_fall_cyc = 0;
   int   fall_cyc = 0;

   int   core_mode = 0;     // 0: core never goes busy, 1: normal run
   logic core_ticket = 1'b0;
   int   core_len = 20;

   miner_job_scheduler_if bus ();

   miner_job_scheduler #(
      .START_HOLD   (START_HOLD),
      .SETTLE       (SETTLE),
      .BUSY_TIMEOUT (BUSY_TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=present required=absent", name);
   endtask

   function automatic logic [255:0] mk_ms(input logic [3:0] id, input logic [31:0] n);
      return {{7{28'hC0DE000, id}}, n};
   endfunction

   function automatic logic [95:0] mk_d2(input logic [3:0] id);
      return {3{28'hDA7A000, id}};
   endfunction

   function automatic res_t mk_res(input logic f, input logic [31:0] n, input logic [3:0] id,
                                   input logic t);
      res_t r;
      r.found = f;
      r.nonce = n;
      r.id = id;
      r.timeout = t;
      return r;
   endfunction

   task automatic push_job(input logic [3:0] id, input logic [31:0] n, input bit expect_launch);
      job_t j;
      @(negedge clk);
      bus.job_valid    = 1'b1;
      bus.job_id       = id;
      bus.job_midstate = mk_ms(id, n);
      bus.job_data2    = mk_d2(id);
      for (int i = 0; i < 200 && !bus.job_ready; i++) @(negedge clk);
      chk("push_job_ready", bus.job_ready, 1);
      if (expect_launch) begin
         j.ms = mk_ms(id, n);
         j.d2 = mk_d2(id);
         exp_job.push_back(j);
      end
      @(negedge clk);
      bus.job_valid = 1'b0;
   endtask

   task automatic wait_results(input int target, input int budget, input string name);
      int i = 0;
      while (n_results < target && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk(name, n_results, target);
   endtask

   task automatic wait_busy(input string name);
      for (int i = 0; i < 100 && !bus.miner_busy; i++) @(negedge clk);
      chk(name, bus.miner_busy, 1);
   endtask

   task automatic wait_res_valid(input string name);
      for (int i = 0; i < 300 && !bus.res_valid; i++) @(negedge clk);
      chk(name, bus.res_valid, 1);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_job_ready"},    bus.job_ready, 1);
      chk({tag, "_start_mining"}, bus.start_mining, 0);
      chk({tag, "_res_valid"},    bus.res_valid, 0);
      chk({tag, "_res_found"},    bus.res_found, 0);
      chk({tag, "_res_nonce"},    bus.res_nonce, 0);
      chk({tag, "_res_id"},       bus.res_id, 0);
      chk({tag, "_res_timeout"},  bus.res_timeout, 0);
      chk({tag, "_midstate"},     |bus.midstate, 0);
      chk({tag, "_data2"},        |bus.data2, 0);
      chk({tag, "_sched_busy"},   bus.sched_busy, 0);
   endtask

   // Core model: busy visible on the 3rd edge after start_mining rises,
   // held core_len cycles; golden_nonce is the low word of the midstate.
   initial begin : core
      logic prev = 1'b0;
      bus.miner_busy   = 1'b0;
      bus.got_ticket   = 1'b0;
      bus.golden_nonce = '0;
      forever begin
         @(negedge clk);
         if (bus.start_mining && !prev && core_mode == 1) begin
            bus.golden_nonce = bus.midstate[31:0];
            bus.got_ticket   = core_ticket;
            repeat (2) @(negedge clk);
            bus.miner_busy = 1'b1;
            repeat (core_len) @(negedge clk);
            bus.miner_busy = 1'b0;
            fall_cyc = cyc;
         end
         prev = bus.start_mining;
      end
   end

   initial begin : monitor
      logic         prev_start = 1'b0;
      logic         prev_valid = 1'b0;
      logic         prev_hs = 1'b0;
      logic         stalled = 1'b0;
      int           run = 0;
      logic [255:0] prev_ms = '0;
      res_t         snap, got, e;
      job_t         j;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            prev_start = 1'b0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            stalled    = 1'b0;
            run        = 0;
         end else begin
            if (bus.start_mining && !prev_start) begin
               if (exp_job.size() == 0) begin
                  fail_now("unexpected_launch");
               end else begin
                  j = exp_job.pop_front();
                  chk("ms_before_start", prev_ms === j.ms, 1);
                  chk("ms_at_start", bus.midstate === j.ms, 1);
                  chk("d2_at_start", bus.data2 === j.d2, 1);
               end
            end
            if (bus.start_mining) begin
               run++;
            end else if (prev_start) begin
               chk("start_len", run, START_HOLD);
               run = 0;
               start_fall_cyc = cyc;
            end

            got.found   = bus.res_found;
            got.nonce   = bus.res_nonce;
            got.id      = bus.res_id;
            got.timeout = bus.res_timeout;
            if (prev_hs) chk("valid_drop_after_hs", bus.res_valid, 0);
            if (stalled && bus.res_valid) chk("res_stable", got, snap);
            if (bus.res_valid && !prev_valid) res_first_cyc = cyc;
            prev_hs = 1'b0;
            stalled = 1'b0;
            if (bus.res_valid) begin
               if (bus.res_ready) begin
                  if (exp_res.size() == 0) begin
                     fail_now("unexpected_result");
                  end else begin
                     e = exp_res.pop_front();
                     chk("res_found", got.found, e.found);
                     chk("res_nonce", got.nonce, e.nonce);
                     chk("res_id", got.id, e.id);
                     chk("res_timeout", got.timeout, e.timeout);
                  end
                  n_results++;
                  prev_hs = 1'b1;
               end else begin
                  stalled = 1'b1;
                  snap = got;
               end
            end
            prev_valid = bus.res_valid;
            prev_start = bus.start_mining;
            prev_ms    = bus.midstate;
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int r0;
      rst              = 1'b1;
      bus.job_valid    = 1'b0;
      bus.job_midstate = '0;
      bus.job_data2    = '0;
      bus.job_id       = '0;
      bus.flush        = 1'b0;
      bus.res_ready    = 1'b1;
      repeat (3) @(negedge clk);
      check_reset("por");
      rst = 1'b0;

      // Ticket found
      core_mode = 1; core_ticket = 1'b1; core_len = 20;
      exp_res.push_back(mk_res(1'b1, 32'h0000_1234, 4'd3, 1'b0));
      push_job(4'd3, 32'h0000_1234, 1'b1);
      wait_results(1, 300, "ticket_done");
      // busy is dropped between edges; the next edge is the first to see it
      // low and opens the SETTLE-cycle window
      chk("ticket_settle_lat", res_first_cyc - fall_cyc, SETTLE + 1);

      // Range exhausted: golden_nonce nonzero but no ticket
      core_ticket = 1'b0;
      exp_res.push_back(mk_res(1'b0, 32'd0, 4'd5, 1'b0));
      push_job(4'd5, 32'h0000_BEEF, 1'b1);
      wait_results(2, 300, "exhaust_done");

      // Core never goes busy
      core_mode = 0;
      exp_res.push_back(mk_res(1'b0, 32'd0, 4'd7, 1'b1));
      push_job(4'd7, 32'h0000_7777, 1'b1);
      wait_results(3, 300, "timeout_done");
      chk("timeout_lat", res_first_cyc - start_fall_cyc, BUSY_TIMEOUT);

      // Back-pressure: job 1 runs, 2 and 3 fill the FIFO, host stalls
      core_mode = 1; core_ticket = 1'b1; core_len = 10;
      bus.res_ready = 1'b0;
      exp_res.push_back(mk_res(1'b1, 32'h11, 4'd1, 1'b0));
      exp_res.push_back(mk_res(1'b1, 32'h22, 4'd2, 1'b0));
      exp_res.push_back(mk_res(1'b1, 32'h33, 4'd3, 1'b0));
      push_job(4'd1, 32'h11, 1'b1);
      wait_busy("bp_busy_seen");
      push_job(4'd2, 32'h22, 1'b1);
      push_job(4'd3, 32'h33, 1'b1);
      chk("bp_job_ready_full", bus.job_ready, 0);
      chk("bp_sched_busy", bus.sched_busy, 1);
      wait_res_valid("bp_valid_seen");
      repeat (6) @(negedge clk);
      chk("bp_stalled_no_hs", n_results, 3);
      chk("bp_still_full", bus.job_ready, 0);
      bus.res_ready = 1'b1;
      wait_results(6, 600, "bp_all_results");

      // Flush in RUN with one job queued
      core_len = 40;
      push_job(4'd9, 32'h99, 1'b1);
      wait_busy("flush_busy_seen");
      repeat (3) @(negedge clk);
      push_job(4'd10, 32'hAA, 1'b0);
      @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush_idle", bus.sched_busy, 0);
      chk("flush_fifo_empty", bus.job_ready, 1);
      chk("flush_start_low", bus.start_mining, 0);
      r0 = n_results;
      repeat (50) @(negedge clk);
      chk("flush_no_result", n_results, r0);
      chk("flush_stays_idle", bus.sched_busy, 0);

      // Push coincident with flush while idle is dropped
      @(negedge clk);
      bus.job_valid    = 1'b1;
      bus.job_id       = 4'd11;
      bus.job_midstate = mk_ms(4'd11, 32'hBB);
      bus.job_data2    = mk_d2(4'd11);
      bus.flush        = 1'b1;
      @(negedge clk);
      bus.job_valid = 1'b0;
      bus.flush     = 1'b0;
      repeat (10) @(negedge clk);
      chk("pushflush_idle", bus.sched_busy, 0);
      chk("pushflush_fifo_empty", bus.job_ready, 1);

      // Flush in REPORT keeps the pending result, drops the queued job
      core_len = 5;
      bus.res_ready = 1'b0;
      exp_res.push_back(mk_res(1'b1, 32'h4321, 4'd12, 1'b0));
      push_job(4'd12, 32'h4321, 1'b1);
      wait_res_valid("rep_valid_seen");
      push_job(4'd13, 32'h55, 1'b0);
      @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("rep_flush_keeps_valid", bus.res_valid, 1);
      chk("rep_flush_keeps_nonce", bus.res_nonce, 32'h4321);
      r0 = n_results;
      bus.res_ready = 1'b1;
      wait_results(r0 + 1, 50, "rep_result_taken");
      repeat (20) @(negedge clk);
      chk("rep_no_relaunch", bus.sched_busy, 0);

      // Reset in RUN with a job queued
      core_len = 40;
      push_job(4'd14, 32'hE0, 1'b1);
      wait_busy("rst_busy_seen");
      repeat (3) @(negedge clk);
      push_job(4'd15, 32'hF0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset("rst_run");
      rst = 1'b0;
      r0 = n_results;
      repeat (50) @(negedge clk);
      chk("rst_no_result", n_results, r0);
      chk("rst_stays_idle", bus.sched_busy, 0);

      chk("scoreboard_empty", exp_res.size(), 0);
      chk("launches_all_seen", exp_job.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
